// File: rtl/dense_layer_seq.sv
// Sequential fixed-point dense layer: one shared MAC walks every neuron's dot
// product, then shifts, saturates and optionally ReLU-clamps into y_out.
module dense_layer_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int N_IN  = 2,
  parameter int N_OUT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         relu_en,
  input  logic [N_IN*WIDTH-1:0]        x_in,
  input  logic [N_IN*N_OUT*WIDTH-1:0]  w_in,
  output logic                         busy,
  output logic                         done,
  output logic [N_OUT*WIDTH-1:0]       y_out
);

  localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1;
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int NW    = N_IN * N_OUT;
  localparam int WW    = (NW > 1) ? $clog2(NW) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [N_IN*WIDTH-1:0]     x_reg;
  logic                      relu_reg;
  logic [IW-1:0]             i_reg;
  logic [OW-1:0]             o_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic [WIDTH-1:0]          y_reg [N_OUT];

  logic signed [WIDTH-1:0]   x_arr [N_IN];
  logic signed [WIDTH-1:0]   w_arr [NW];
  logic [WW-1:0]             widx;
  logic signed [WIDTH-1:0]   x_sel, w_sel;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_sum, shifted;
  logic [WIDTH-1:0]          sat_val, post_val;
  logic                      last_i, last_o;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
      assign x_arr[gi] = x_reg[gi*WIDTH +: WIDTH];
    end
    for (genvar gi = 0; gi < NW; gi++) begin : g_w
      assign w_arr[gi] = w_in[gi*WIDTH +: WIDTH];
    end
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_y
      assign y_out[gi*WIDTH +: WIDTH] = y_reg[gi];
    end
  endgenerate

  assign widx    = WW'(o_reg) * WW'(N_IN) + WW'(i_reg);
  assign x_sel   = x_arr[i_reg];
  assign w_sel   = w_arr[widx];
  assign prod    = (2*WIDTH)'(x_sel) * (2*WIDTH)'(w_sel);
  assign acc_sum = acc_reg + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign last_i  = (i_reg == IW'(N_IN-1));
  assign last_o  = (o_reg == OW'(N_OUT-1));

  // Arithmetic shift floors toward -inf; then clamp to the WIDTH range.
  always_comb begin
    shifted = acc_reg >>> FRAC;
    if (shifted > SAT_MAX)
      sat_val = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN)
      sat_val = SAT_MIN[WIDTH-1:0];
    else
      sat_val = shifted[WIDTH-1:0];
    post_val = (relu_reg && sat_val[WIDTH-1]) ? '0 : sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (last_i) state_next = STORE;
      STORE:   state_next = last_o ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg    <= '0;
      relu_reg <= 1'b0;
      i_reg    <= '0;
      o_reg    <= '0;
      acc_reg  <= '0;
      for (int k = 0; k < N_OUT; k++) y_reg[k] <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          x_reg    <= x_in;
          relu_reg <= relu_en;
          i_reg    <= '0;
          o_reg    <= '0;
          acc_reg  <= '0;
        end
        MAC: begin
          acc_reg <= acc_sum;
          if (!last_i) i_reg <= i_reg + 1'b1;
        end
        STORE: begin
          y_reg[o_reg] <= post_val;
          acc_reg      <= '0;
          i_reg        <= '0;
          if (!last_o) o_reg <= o_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
